// File: rtl/calc1_scheduler_if.sv
// Requester and shared-ALU signal bundle for calc1_scheduler.
// The scheduler sits on the slave side; the requesters and the ALU sit on the master side.
interface calc1_scheduler_if #(
   parameter int DATA_W = 32,
   parameter int NPORT  = 4
);
   logic [4*NPORT-1:0]      req_cmd_in;
   logic [DATA_W*NPORT-1:0] req_data_in;
   logic [2*NPORT-1:0]      out_resp;
   logic [DATA_W*NPORT-1:0] out_data;
   logic                    alu_req;
   logic [3:0]              alu_cmd;
   logic [DATA_W-1:0]       alu_op1;
   logic [DATA_W-1:0]       alu_op2;
   logic                    alu_done;
   logic [DATA_W-1:0]       alu_result;
   logic                    alu_ovf;

   modport master (
      output req_cmd_in, req_data_in,
      output alu_done, alu_result, alu_ovf,
      input  out_resp, out_data,
      input  alu_req, alu_cmd, alu_op1, alu_op2
   );

   modport slave (
      input  req_cmd_in, req_data_in,
      input  alu_done, alu_result, alu_ovf,
      output out_resp, out_data,
      output alu_req, alu_cmd, alu_op1, alu_op2
   );
endinterface

// File: rtl/calc1_scheduler.sv
// Per-port command FSMs sharing one ALU through a round-robin grant.
// One outstanding command per port; responses are one-cycle pulses.
module calc1_scheduler #(
   parameter int DATA_W = 32,
   parameter int NPORT  = 4
) (
   input logic c_clk,
   input logic reset,
   calc1_scheduler_if.slave bus
);
   localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic [2:0] {
      P_IDLE, P_OP2, P_PEND, P_EXEC, P_RESP
   } p_state_t;

   typedef enum logic {
      A_IDLE, A_BUSY
   } a_state_t;

   p_state_t          pst  [NPORT];
   logic [3:0]        pcmd [NPORT];
   logic [DATA_W-1:0] pop1 [NPORT];
   logic [DATA_W-1:0] pop2 [NPORT];
   a_state_t          ast;
   logic [IW-1:0]     last;
   logic [IW-1:0]     sel;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_vld;

   function automatic logic cmd_ok(input logic [3:0] c);
      case (c)
         4'd1, 4'd2, 4'd5, 4'd6: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // Search starts at the port after the last grant.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NPORT; k++) begin
         idx = (int'(last) + k) % NPORT;
         if (!gnt_vld && pst[idx] == P_PEND) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(idx);
         end
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPORT; i++) begin
            pst[i]  <= P_IDLE;
            pcmd[i] <= '0;
            pop1[i] <= '0;
            pop2[i] <= '0;
         end
         bus.out_resp <= '0;
         bus.out_data <= '0;
         bus.alu_req  <= 1'b0;
         bus.alu_cmd  <= '0;
         bus.alu_op1  <= '0;
         bus.alu_op2  <= '0;
         ast          <= A_IDLE;
         sel          <= '0;
         last         <= IW'(NPORT - 1);
      end else begin
         bus.alu_req <= 1'b0;
         for (int i = 0; i < NPORT; i++) begin
            case (pst[i])
               P_IDLE: begin
                  if (bus.req_cmd_in[i*4 +: 4] != 4'd0) begin
                     pcmd[i] <= bus.req_cmd_in[i*4 +: 4];
                     pop1[i] <= bus.req_data_in[i*DATA_W +: DATA_W];
                     pst[i]  <= P_OP2;
                  end
               end
               P_OP2: begin
                  pop2[i] <= bus.req_data_in[i*DATA_W +: DATA_W];
                  if (cmd_ok(pcmd[i])) begin
                     pst[i] <= P_PEND;
                  end else begin
                     pst[i]                         <= P_RESP;
                     bus.out_resp[i*2 +: 2]         <= 2'd2;
                     bus.out_data[i*DATA_W +: DATA_W] <= '0;
                  end
               end
               P_RESP: begin
                  pst[i]                         <= P_IDLE;
                  bus.out_resp[i*2 +: 2]         <= 2'd0;
                  bus.out_data[i*DATA_W +: DATA_W] <= '0;
               end
               default: ;
            endcase
         end
         unique case (ast)
            A_IDLE: begin
               if (gnt_vld) begin
                  bus.alu_req  <= 1'b1;
                  bus.alu_cmd  <= pcmd[gnt_idx];
                  bus.alu_op1  <= pop1[gnt_idx];
                  bus.alu_op2  <= pop2[gnt_idx];
                  pst[gnt_idx] <= P_EXEC;
                  sel          <= gnt_idx;
                  last         <= gnt_idx;
                  ast          <= A_BUSY;
               end
            end
            A_BUSY: begin
               if (bus.alu_done) begin
                  bus.out_data[sel*DATA_W +: DATA_W] <= bus.alu_result;
                  bus.out_resp[sel*2 +: 2] <= bus.alu_ovf ? 2'd2 : 2'd1;
                  pst[sel] <= P_RESP;
                  ast      <= A_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_calc1_scheduler.sv
// Directed plus randomized bench for calc1_scheduler with a behavioural ALU
// and a transaction-level reference model (round-robin order and results).
module tb_calc1_scheduler;
   localparam int DW = 32;
   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   calc1_scheduler_if #(.DATA_W(DW), .NPORT(NP)) bus ();

   calc1_scheduler #(.DATA_W(DW), .NPORT(NP)) dut (
      .c_clk (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
   } iss_t;

   typedef struct {
      int          cyc;
      int          port;
      logic [1:0]  resp;
      logic [31:0] data;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int bad_data = 0;
   int stab_err = 0;
   int lat = 1;
   bit alu_auto = 1'b1;
   bit force_done = 1'b0;
   int m_last = NP - 1;

   logic [3:0]  b_cmd [NP];
   logic [31:0] b_a   [NP];
   logic [31:0] b_b   [NP];

   always @(posedge clk) cyc++;

   function automatic logic [32:0] ref_alu(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      case (c)
         4'd1:    return {1'b0, a} + {1'b0, b};
         4'd2:    return {(a < b), a - b};
         4'd5:    return {1'b0, a << b[4:0]};
         4'd6:    return {1'b0, a >> b[4:0]};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   function automatic bit is_valid(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
   endfunction

   // Behavioural ALU: completes lat cycles after the issue strobe.
   int          rem = 0;
   logic [3:0]  rc;
   logic [31:0] ra;
   logic [31:0] rb;
   always @(negedge clk) begin
      logic [32:0] r;
      bus.alu_done   = force_done;
      bus.alu_result = 32'hDEAD_BEEF;
      bus.alu_ovf    = 1'b0;
      if (rst) begin
         rem = 0;
      end else if (alu_auto) begin
         if (bus.alu_req) begin
            rem = lat;
            rc  = bus.alu_cmd;
            ra  = bus.alu_op1;
            rb  = bus.alu_op2;
         end
         if (rem > 0) begin
            if (bus.alu_cmd !== rc || bus.alu_op1 !== ra || bus.alu_op2 !== rb)
               stab_err++;
            rem--;
            if (rem == 0) begin
               r = ref_alu(rc, ra, rb);
               bus.alu_done   = 1'b1;
               bus.alu_result = r[31:0];
               bus.alu_ovf    = r[32];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.alu_req)
         iss_q.push_back('{cyc, bus.alu_cmd, bus.alu_op1, bus.alu_op2});
      for (int p = 0; p < NP; p++) begin
         if (bus.out_resp[p*2 +: 2] != 2'd0)
            rsp_q.push_back('{cyc, p + 1, bus.out_resp[p*2 +: 2],
                              bus.out_data[p*32 +: 32]});
         else if (bus.out_data[p*32 +: 32] != 32'd0)
            bad_data++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drv(input int p, input logic [3:0] c, input logic [31:0] d);
      bus.req_cmd_in[p*4 +: 4]   = c;
      bus.req_data_in[p*32 +: 32] = d;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      m_last = NP - 1;
      step(1);
   endtask

   task automatic clear_batch();
      for (int p = 0; p < NP; p++) begin
         b_cmd[p] = 4'd0;
         b_a[p]   = $urandom;
         b_b[p]   = $urandom;
      end
   endtask

   task automatic run_batch(input string tag);
      int order[$];
      int rcyc[NP];
      int n_rsp;
      int t0;
      int k;
      int hits;
      logic [32:0] r;
      rsp_t rec;
      iss_q.delete();
      rsp_q.delete();
      n_rsp = 0;
      for (int s = 1; s <= NP; s++) begin
         k = (m_last + s) % NP;
         if (is_valid(b_cmd[k])) order.push_back(k);
      end
      if (order.size() > 0) m_last = order[order.size()-1];
      for (int p = 0; p < NP; p++) if (b_cmd[p] != 4'd0) n_rsp++;
      t0 = cyc;
      for (int p = 0; p < NP; p++) drv(p, b_cmd[p], b_a[p]);
      step();
      for (int p = 0; p < NP; p++) drv(p, 4'd0, b_b[p]);
      step();
      for (int p = 0; p < NP; p++) drv(p, 4'd0, $urandom);
      for (int i = 0; i < 200 && rsp_q.size() < n_rsp; i++) step();
      step(3);
      chk({tag, " rsp count"}, rsp_q.size(), n_rsp);
      chk({tag, " issue count"}, iss_q.size(), order.size());
      for (int i = 0; i < order.size() && i < iss_q.size(); i++) begin
         chk({tag, " grant cmd"}, iss_q[i].cmd, b_cmd[order[i]]);
         chk({tag, " grant op1"}, iss_q[i].a, b_a[order[i]]);
         chk({tag, " grant op2"}, iss_q[i].b, b_b[order[i]]);
      end
      for (int p = 0; p < NP; p++) begin
         rcyc[p] = -1;
         if (b_cmd[p] != 4'd0) begin
            hits = 0;
            rec  = '{0, 0, 2'd0, 32'd0};
            foreach (rsp_q[j]) if (rsp_q[j].port == p + 1) begin
               hits++;
               rec = rsp_q[j];
            end
            rcyc[p] = rec.cyc;
            chk({tag, " rsp hits"}, hits, 1);
            if (is_valid(b_cmd[p])) begin
               r = ref_alu(b_cmd[p], b_a[p], b_b[p]);
               chk({tag, " rsp code"}, rec.resp, r[32] ? 2'd2 : 2'd1);
               chk({tag, " rsp data"}, rec.data, r[31:0]);
            end else begin
               chk({tag, " bad rsp code"}, rec.resp, 2'd2);
               chk({tag, " bad rsp data"}, rec.data, 32'd0);
               chk({tag, " bad rsp cycle"}, rec.cyc, t0 + 2);
            end
         end
      end
      for (int i = 0; i < order.size(); i++)
         chk({tag, " rsp cycle"}, rcyc[order[i]], t0 + 3 + lat + i*(lat + 1));
   endtask

   initial begin
      logic [3:0] tbl [10];
      int t0;
      tbl = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7, 4'd15, 4'd1, 4'd2};
      bus.req_cmd_in  = '0;
      bus.req_data_in = '0;
      step(3);
      chk("reset out_resp", bus.out_resp, 0);
      chk("reset out_data", bus.out_data, 0);
      chk("reset alu_req", bus.alu_req, 0);
      chk("reset alu_cmd", bus.alu_cmd, 0);
      chk("reset alu_ops", {bus.alu_op1, bus.alu_op2}, 0);
      rst = 1'b0;
      step(2);

      lat = 1;
      clear_batch();
      b_cmd[0] = 4'd1; b_a[0] = 32'd255; b_b[0] = 32'd1;
      run_batch("add255");

      clear_batch();
      b_cmd[2] = 4'd1; b_a[2] = 32'd1; b_b[2] = 32'd4;
      b_cmd[3] = 4'd1; b_a[3] = 32'd2; b_b[3] = 32'd8;
      run_batch("p3p4");

      clear_batch();
      b_cmd[1] = 4'd2; b_a[1] = 32'd1; b_b[1] = 32'd100;
      run_batch("sub_uf");

      clear_batch();
      b_cmd[0] = 4'd3;
      run_batch("invalid");

      iss_q.delete();
      rsp_q.delete();
      t0 = cyc;
      drv(0, 4'd1, 32'd7);  step();
      drv(0, 4'd2, 32'd9);  step();
      drv(0, 4'd0, 32'd0);  step(2);
      drv(0, 4'd1, 32'd11); step();
      drv(0, 4'd1, 32'd20); step();
      drv(0, 4'd0, 32'd5);  step();
      drv(0, 4'd0, 32'd0);  step(8);
      m_last = 0;
      chk("busy issue count", iss_q.size(), 2);
      chk("busy rsp count", rsp_q.size(), 2);
      if (iss_q.size() == 2 && rsp_q.size() == 2) begin
         chk("op2 cmd ignored", iss_q[0].cmd, 4'd1);
         chk("op2 data kept", {iss_q[0].a, iss_q[0].b}, {32'd7, 32'd9});
         chk("first rsp", {rsp_q[0].cyc, rsp_q[0].data}, {t0 + 4, 32'd16});
         chk("resp-cycle cmd", {iss_q[1].a, iss_q[1].b}, {32'd20, 32'd5});
         chk("second rsp", {rsp_q[1].cyc, rsp_q[1].data}, {t0 + 9, 32'd25});
      end

      apply_reset();
      lat = 3;
      for (int rep = 0; rep < 2; rep++) begin
         clear_batch();
         for (int p = 0; p < NP; p++) b_cmd[p] = tbl[$urandom_range(1, 4)];
         run_batch("all4");
      end

      for (int rep = 0; rep < 6; rep++) begin
         lat = $urandom_range(1, 3);
         clear_batch();
         for (int p = 0; p < NP; p++) b_cmd[p] = tbl[$urandom_range(0, 9)];
         run_batch("random");
      end

      lat = 1;
      alu_auto = 1'b0;
      iss_q.delete();
      rsp_q.delete();
      drv(0, 4'd1, 32'd3); step();
      drv(0, 4'd0, 32'd4); step();
      drv(0, 4'd0, 32'd0);
      for (int i = 0; i < 10 && iss_q.size() == 0; i++) step();
      chk("mid issue", iss_q.size(), 1);
      rst = 1'b1;
      step();
      chk("mid rst resp", bus.out_resp, 0);
      chk("mid rst alu", {bus.alu_req, bus.alu_cmd, bus.alu_op1, bus.alu_op2}, 0);
      step();
      rst = 1'b0;
      m_last = NP - 1;
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      step(5);
      chk("late done rsp", rsp_q.size(), 0);
      chk("late done reissue", iss_q.size(), 1);
      chk("late done outs", {bus.out_resp, bus.out_data, bus.alu_req}, 0);
      alu_auto = 1'b1;
      clear_batch();
      b_cmd[3] = 4'd6; b_a[3] = 32'h8000_0000; b_b[3] = 32'd4;
      run_batch("after rst");

      chk("data while idle", bad_data, 0);
      chk("alu operand hold", stab_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
